// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core.
//   sqi_data_t   : one 4b nibble on the SQI bus.
//   SQI_CMD_READ : SQI memory read command byte.
//   fet_state_t  : fetch unit phase (GAP, CMD, ADDR, DUMMY, DATA).
//   max_u        : elaboration-time maximum of two unsigned values.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  localparam logic [7:0] SQI_CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    GAP,
    CMD,
    ADDR,
    DUMMY,
    DATA
  } fet_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/idli_fetch_m.sv
// Instruction fetch unit. Issues the SQI read sequence (command, address,
// dummy turnaround) and then streams instruction/immediate nibbles from
// memory to the decoder, one nibble per cycle, tracking the word PC.
//
// Ports:
//   i_fet_gck          clock
//   i_fet_rst_n        asynchronous active-low reset
//   i_fet_stall        backend cannot accept a nibble this cycle
//   i_fet_redirect     abandon the stream and restart at i_fet_redirect_pc
//   i_fet_redirect_pc  redirect target word address
//   o_sqi_cs_n         memory chip select (active-low)
//   o_sqi_sck_en       enable for the externally gated memory clock
//   o_sqi_data         command/address nibble to memory
//   o_sqi_oe           drive o_sqi_data onto the bus
//   i_sqi_data         data nibble from memory
//   o_fet_enc          nibble to decode
//   o_fet_enc_vld      o_fet_enc is valid
//   o_fet_pc           word PC of the word currently streaming
module idli_fetch_m
  import idli_pkg::*;
#(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int unsigned ADDR_NIBBLES  = 6,
  parameter int unsigned DUMMY_NIBBLES = 2
) (
  input  logic        i_fet_gck,
  input  logic        i_fet_rst_n,
  input  logic        i_fet_stall,
  input  logic        i_fet_redirect,
  input  logic [15:0] i_fet_redirect_pc,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output sqi_data_t   o_sqi_data,
  output logic        o_sqi_oe,
  input  sqi_data_t   i_sqi_data,
  output sqi_data_t   o_fet_enc,
  output logic        o_fet_enc_vld,
  output logic [15:0] o_fet_pc
);

  localparam int unsigned CNT_MAX = max_u(max_u(2, ADDR_NIBBLES), max_u(DUMMY_NIBBLES, 4));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned ADDR_W  = 4 * ADDR_NIBBLES;

  fet_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       pc_q, pc_d;

  logic              advance;
  logic [ADDR_W-1:0] byte_addr;
  logic [ADDR_W-1:0] addr_sh;
  logic [CNT_W-1:0]  addr_idx;

  always_ff @(posedge i_fet_gck or negedge i_fet_rst_n) begin
    if (!i_fet_rst_n) begin
      state_q <= CMD;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  // Redirect beats stall: either one freezes the memory clock this cycle.
  assign advance = ~i_fet_stall & ~i_fet_redirect;

  // Byte address of the current word, sent most-significant nibble first.
  assign byte_addr = ADDR_W'({pc_q, 1'b0});
  assign addr_idx  = CNT_W'(ADDR_NIBBLES - 1) - cnt_q;
  assign addr_sh   = byte_addr >> {addr_idx, 2'b00};

  assign o_fet_enc = i_sqi_data;
  assign o_fet_pc  = pc_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_d          = pc_q;
    o_sqi_cs_n    = 1'b1;
    o_sqi_sck_en  = 1'b0;
    o_sqi_data    = '0;
    o_sqi_oe      = 1'b0;
    o_fet_enc_vld = 1'b0;

    unique case (state_q)
      GAP: begin
        if (advance) state_d = CMD;
      end
      CMD: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = advance;
        o_sqi_oe     = 1'b1;
        o_sqi_data   = (cnt_q == '0) ? SQI_CMD_READ[7:4] : SQI_CMD_READ[3:0];
        if (advance) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ADDR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ADDR: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = advance;
        o_sqi_oe     = 1'b1;
        o_sqi_data   = addr_sh[3:0];
        if (advance) begin
          if (cnt_q == CNT_W'(ADDR_NIBBLES - 1)) begin
            state_d = (DUMMY_NIBBLES == 0) ? DATA : DUMMY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DUMMY: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = advance;
        if (advance) begin
          if (cnt_q == CNT_W'(DUMMY_NIBBLES - 1)) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        o_sqi_cs_n    = 1'b0;
        o_sqi_sck_en  = advance;
        o_fet_enc_vld = advance;
        if (advance) begin
          if (cnt_q == CNT_W'(3)) begin
            cnt_d = '0;
            pc_d  = pc_q + 16'd1;
            // Re-issue the address on wrap instead of trusting the memory's own wrap.
            if (pc_q == 16'hFFFF) state_d = GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = GAP;
        cnt_d   = '0;
      end
    endcase

    if (i_fet_redirect) begin
      state_d = GAP;
      cnt_d   = '0;
      pc_d    = i_fet_redirect_pc;
    end

    // Reset state is CMD, but the bus must be idle while reset is held.
    if (!i_fet_rst_n) begin
      o_sqi_cs_n    = 1'b1;
      o_sqi_sck_en  = 1'b0;
      o_sqi_data    = '0;
      o_sqi_oe      = 1'b0;
      o_fet_enc_vld = 1'b0;
    end
  end

endmodule

// File: tb/tb_idli_fetch_m.sv
// Testbench for idli_fetch_m: SQI memory model plus a scoreboard of
// expected {pc, nibble} pairs loaded on reset/redirect and popped on vld.
module tb_idli_fetch_m;
  import idli_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        cs_n;
  logic        sck_en;
  sqi_data_t   sqi_out;
  logic        oe;
  sqi_data_t   sqi_in;
  sqi_data_t   enc;
  logic        vld;
  logic [15:0] fet_pc;

  idli_fetch_m #(
    .RESET_PC     (16'h0000),
    .ADDR_NIBBLES (6),
    .DUMMY_NIBBLES(2)
  ) u_dut (
    .i_fet_gck        (clk),
    .i_fet_rst_n      (rst_n),
    .i_fet_stall      (stall),
    .i_fet_redirect   (redirect),
    .i_fet_redirect_pc(redirect_pc),
    .o_sqi_cs_n       (cs_n),
    .o_sqi_sck_en     (sck_en),
    .o_sqi_data       (sqi_out),
    .o_sqi_oe         (oe),
    .i_sqi_data       (sqi_in),
    .o_fet_enc        (enc),
    .o_fet_enc_vld    (vld),
    .o_fet_pc         (fet_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory contents, one 16b word per word address.
  function automatic logic [15:0] ref_word(input logic [15:0] w);
    if (w == 16'h0000) return 16'h1234;
    if (w == 16'h0001) return 16'h5678;
    return w ^ 16'hA5C3;
  endfunction

  // SQI memory model: counts clocked nibbles while selected.
  int          k;
  logic [7:0]  mcmd;
  logic [23:0] maddr;
  logic [24:0] nib_idx;
  logic [15:0] mword;

  always @(posedge clk) begin
    if (cs_n) k <= 0;
    else if (sck_en) begin
      if (k < 2) mcmd <= {mcmd[3:0], sqi_out};
      else if (k < 8) maddr <= {maddr[19:0], sqi_out};
      k <= k + 1;
    end
  end

  always_comb begin
    nib_idx = {maddr, 1'b0} + 25'(k - 10);
    mword   = ref_word(nib_idx[17:2]);
    sqi_in  = 4'h0;
    if (k >= 10) sqi_in = 4'(mword >> (4 * (3 - int'(nib_idx[1:0]))));
  end

  // Scoreboard.
  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  enc;
  } sb_t;
  sb_t sb_q[$];
  sb_t sb_e;

  task automatic sb_load(input logic [15:0] pc);
    logic [15:0] p;
    logic [15:0] wd;
    sb_q.delete();
    for (int w = 0; w < 64; w++) begin
      p  = pc + 16'(w);
      wd = ref_word(p);
      for (int j = 0; j < 4; j++) sb_q.push_back({p, wd[15-4*j -: 4]});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && vld) begin
      if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        sb_e = sb_q.pop_front();
        check("enc", 32'(enc), 32'(sb_e.enc));
        check("pc", 32'(fet_pc), 32'(sb_e.pc));
      end
    end
  end

  logic [3:0] seen_data[16];
  logic       seen_cs[16];
  logic       seen_oe[16];

  task automatic wait_vld(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n < 16) begin
        seen_data[n] = sqi_out;
        seen_cs[n]   = cs_n;
        seen_oe[n]   = oe;
      end
    end while (!vld && n < 40);
    if (!vld) check("vld_timeout", 32'd0, 32'd1);
  endtask

  // Verifies the setup phase recorded by the last wait_vld.
  // off=1 when a GAP cycle precedes CMD.
  task automatic check_setup(input string tag, input logic [15:0] pc, input int n,
                             input int exp_n, input int off);
    logic [23:0] a;
    a = {7'b0, pc, 1'b0};
    check({tag, "_latency"}, 32'(n), 32'(exp_n));
    if (off == 1) check({tag, "_gap_cs"}, 32'(seen_cs[1]), 32'd1);
    check({tag, "_cmd_hi"}, 32'(seen_data[off+1]), 32'h0);
    check({tag, "_cmd_lo"}, 32'(seen_data[off+2]), 32'h3);
    for (int i = 0; i < 6; i++)
      check({tag, "_addr_nib"}, 32'(seen_data[off+3+i]), 32'(a[23-4*i -: 4]));
    check({tag, "_oe_addr"}, 32'(seen_oe[off+3]), 32'd1);
    check({tag, "_oe_dummy"}, 32'(seen_oe[off+9]), 32'd0);
    check({tag, "_mem_cmd"}, 32'(mcmd), 32'h03);
    check({tag, "_mem_addr"}, 32'(maddr), 32'(a));
    check({tag, "_pc"}, 32'(fet_pc), 32'(pc));
  endtask

  task automatic do_redirect(input logic [15:0] pc, input logic with_stall);
    @(posedge clk); #1;
    redirect    = 1'b1;
    redirect_pc = pc;
    stall       = with_stall;
    sb_load(pc);
    @(negedge clk);
    check("redir_vld", 32'(vld), 32'd0);
    check("redir_sck", 32'(sck_en), 32'd0);
    @(posedge clk); #1;
    redirect = 1'b0;
    stall    = 1'b0;
  endtask

  int n;

  initial begin
    rst_n       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    #1 rst_n = 1'b0;
    sb_load(16'h0000);
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sck_en", 32'(sck_en), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_data", 32'(sqi_out), 32'd0);
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_pc", 32'(fet_pc), 32'h0);

    // Reset release: first nibble on the 11th clock.
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_vld(n);
    check_setup("boot", 16'h0000, n, 11, 0);

    // Stall 3 cycles after two nibbles of word 0.
    @(posedge clk); #1;
    @(posedge clk); #1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_vld", 32'(vld), 32'd0);
      check("stall_sck", 32'(sck_en), 32'd0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    repeat (8) @(posedge clk);

    // Redirect mid-DATA.
    do_redirect(16'h0100, 1'b0);
    wait_vld(n);
    check_setup("redir", 16'h0100, n, 12, 1);

    // Redirect and stall together during ADDR.
    do_redirect(16'h0040, 1'b0);
    repeat (4) @(negedge clk);
    do_redirect(16'h0300, 1'b1);
    wait_vld(n);
    check_setup("redir_stall", 16'h0300, n, 12, 1);

    // PC wrap from 16'hFFFF re-issues address 0.
    do_redirect(16'hFFFF, 1'b0);
    wait_vld(n);
    check_setup("ffff", 16'hFFFF, n, 12, 1);
    for (int i = 0; i < 3; i++) begin
      wait_vld(n);
      check("ffff_stream", 32'(n), 32'd1);
    end
    wait_vld(n);
    check_setup("wrap", 16'h0000, n, 12, 1);

    // Asynchronous reset mid-ADDR.
    do_redirect(16'h0123, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb_load(16'h0000);
    #1;
    check("arst_cs_n", 32'(cs_n), 32'd1);
    check("arst_vld", 32'(vld), 32'd0);
    check("arst_oe", 32'(oe), 32'd0);
    check("arst_sck", 32'(sck_en), 32'd0);
    check("arst_pc", 32'(fet_pc), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_vld(n);
    check_setup("rerst", 16'h0000, n, 11, 0);
    repeat (20) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/idli_fetch_m.md
Name: idli_fetch_m

Overview:
Instruction fetch unit. Drives the SQI memory read sequence and streams instruction and immediate nibbles, 4b per cycle, into the decoder's i_dcd_enc / i_dcd_enc_vld input. Tracks the word PC of the instruction being delivered. Accepts redirects from execute and stalls from the backend.

Parameters:
RESET_PC, 16'h0000, word address fetched after reset.
ADDR_NIBBLES, 6, address nibbles sent after the command (24b byte address).
DUMMY_NIBBLES, 2, turnaround nibbles between address and data.

Ports:
i_fet_gck  in  1  clock.
i_fet_rst_n  in  1  reset, asynchronous, active-low.
i_fet_stall  in  1  backend cannot accept a nibble this cycle.
i_fet_redirect  in  1  abandon the current stream and restart at i_fet_redirect_pc.
i_fet_redirect_pc  in  16  target word address.
o_sqi_cs_n  out  1  memory chip select, active-low.
o_sqi_sck_en  out  1  enable for the externally gated memory clock.
o_sqi_data  out  4  command/address nibble to memory.
o_sqi_oe  out  1  drive o_sqi_data onto the bus.
i_sqi_data  in  4  data nibble from memory (sqi_data_t).
o_fet_enc  out  4  nibble to decode (sqi_data_t).
o_fet_enc_vld  out  1  o_fet_enc is valid.
o_fet_pc  out  16  word PC of the instruction or immediate word currently streaming.

Behaviour:
- Reset values: state CMD, pc=RESET_PC, nibble counter 0. Outputs: o_sqi_cs_n=1, o_sqi_sck_en=0, o_sqi_oe=0, o_sqi_data=0, o_fet_enc_vld=0, o_fet_pc=RESET_PC.
- States:
  - GAP: cs_n=1, sck_en=0; 1 cycle; next state is CMD.
  - CMD: 2 nibbles of SQI_CMD_READ (8'h03), high nibble first; oe=1.
  - ADDR: ADDR_NIBBLES nibbles of the byte address {pc,1'b0} zero-extended to 4*ADDR_NIBBLES bits, MS nibble first; oe=1.
  - DUMMY: DUMMY_NIBBLES cycles; oe=0.
  - DATA: oe=0. o_fet_enc = i_sqi_data (combinational). o_fet_enc_vld=1 unless stall or redirect is asserted.
- In CMD, ADDR, DUMMY and DATA: cs_n=0 and sck_en = ~i_fet_stall.
- A single counter sized for max(2, ADDR_NIBBLES, DUMMY_NIBBLES, 4) counts nibbles within each phase and resets on every state change.
- Stall: the counter, state and pc hold; sck_en=0, so memory does not advance; vld=0.
- DATA counter wraps 3→0 on each accepted nibble. pc increments on the 4th accepted nibble, so o_fet_pc changes on the cycle after the last nibble of a word.
- Latency: first valid nibble appears on the 11th clock after reset deasserts (2+6+2 setup cycles, then nibble 0), with no stalls. After a redirect it appears on the 12th clock after the redirect cycle (GAP+10).
- Redirect: accepted in any state, including during a stall. Redirect beats stall.
  - Same cycle: vld=0, sck_en=0.
  - Next cycle: pc=i_fet_redirect_pc, counter=0, state GAP.
  - A partially delivered instruction is abandoned; the decoder must be flushed by the same redirect.
- PC wrap: when pc increments from 16'hFFFF, it becomes 16'h0000 and the state goes to GAP. The address is then re-issued rather than relying on the memory's internal wrap.
- Immediates need no special handling: they are further 4-nibble words in the stream.

Decomposition:
- idli_pkg: add SQI_CMD_READ (8'h03) and fet_state_t (GAP, CMD, ADDR, DUMMY, DATA). sqi_data_t already lives there.
- No sub-module: the phase counter and state machine stay in idli_fetch_m.

Test Plan:
- Reset release, RESET_PC=0, memory model returns 16'h1234, 16'h5678 → o_sqi_data sequence 0,3,0,0,0,0,0,0; o_fet_enc 1,2,3,4,5,6,7,8 from cycle 10 onward; o_fet_pc goes 0→1 after nibble 4.
- Stall for 3 cycles after nibble 2 of word 0 → vld=0 and sck_en=0 for those 3 cycles; the stream resumes with nibble 3, with nothing lost or duplicated.
- Redirect to 16'h0100 mid-DATA → 1 cycle with cs_n high. Address nibbles are 0,0,0,2,0,0 (byte address 0x000200); the first nibble of word 0x0100 arrives 11 cycles after GAP; o_fet_pc=16'h0100.
- Redirect and stall asserted together during ADDR → the redirect is taken and the next state is GAP.
- Redirect to 16'hFFFF, stream 4 nibbles → pc wraps to 0, GAP is inserted, address 0 is re-issued.
- Reset asserted mid-ADDR → cs_n=1 and vld=0 immediately (asynchronously). After release the sequence restarts from CMD at RESET_PC.
